program_store: RTL and testbench
================================

Name: program_store

Overview:
Loadable program and delay store for the glitch sequencer, replacing the hard-coded instruction and delay lookup.
- A host loads instructions, delay lengths, program length and loop count at run time.
- On start, the block streams instructions to the sequencer over a valid/ready handshake and repeats the program a configurable number of times.
- It also serves delay-table lookups.
- It sits between the host/config interface and the instruction-execution FSM.

Parameters:
INSTR_W, 12, instruction width; field layout {op[1:0], bus, data[7:0], ack} at the default.
PROG_DEPTH, 64, instruction memory entries.
DELAY_W, 32, delay length width, in clock cycles.
NUM_DELAYS, 16, delay table entries.
LOOP_W, 8, loop count width.
PA = clog2(PROG_DEPTH), DA = clog2(NUM_DELAYS); derived, not overridable.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ld_instr_en  in  1  write instruction memory
ld_instr_addr  in  PA  instruction write address
ld_instr_data  in  INSTR_W  instruction write data
ld_delay_en  in  1  write delay table
ld_delay_addr  in  DA  delay write address
ld_delay_data  in  DELAY_W  delay write data
ld_len_en  in  1  load program length
ld_len  in  PA+1  program length in instructions
ld_loop_en  in  1  load loop count
ld_loop  in  LOOP_W  extra passes; total passes = ld_loop+1
ld_err  out  1  pulse: load attempted while busy
start  in  1  begin execution
abort  in  1  stop execution
busy  out  1  high outside IDLE
instr_valid  out  1  instr/instr_pt valid
instr_ready  in  1  sequencer accepts instr
instr  out  INSTR_W  current instruction
instr_pt  out  PA  address of current instruction
done  out  1  pulse: all passes complete
aborted  out  1  pulse: abort honoured
dly_rd_en  in  1  delay lookup request
dly_rd_num  in  8  delay index
dly_rd_valid  out  1  lookup result valid, one cycle after request
dly_rd_len  out  DELAY_W  looked-up delay

Behaviour:
Reset values:
- All outputs 0.
- prog_len = 0, loop_cnt = 0, pc = 0, pass counter = 0, state IDLE.
- Memory contents are not reset.

Loads:
- Loads are accepted only in IDLE, one cycle after the enable.
- Any ld_*_en while busy is ignored and pulses ld_err for 1 cycle on the next cycle.
- ld_len > PROG_DEPTH saturates to PROG_DEPTH.

FSM states IDLE, FETCH, OFFER, DONE. Memories are synchronous read with 1-cycle latency.
- IDLE: on start, pc <= 0 and pass <= 0.
  - If prog_len == 0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: present pc to the RAM, go to OFFER. The data registers into instr.
- OFFER: instr_valid = 1; instr and instr_pt are stable until the handshake.
  - On instr_valid & instr_ready with pc == prog_len-1 and pass == loop_cnt: go to DONE.
  - On that handshake at the last instruction with pass < loop_cnt: pass++, pc <= 0, go to FETCH.
  - On any other handshake: pc++, go to FETCH.
  - Maximum throughput is 1 instruction per 2 cycles.
- DONE: done = 1 for one cycle, then IDLE.
- start while busy is ignored.
- abort in any non-IDLE state: next cycle IDLE, instr_valid = 0, aborted pulses, done is not asserted.
  - abort outranks a same-cycle handshake. The handshake still counts as accepted by the sequencer, but no further fetch occurs.
- abort in IDLE does nothing.
- start and abort together in IDLE: start is ignored.
- Loads to the instruction RAM while busy are blocked (ld_err), so the running program is immutable.

Delay lookup:
- Independent of the FSM; usable in any state.
- dly_rd_valid follows dly_rd_en by 1 cycle.
- dly_rd_num >= NUM_DELAYS returns 0.
- A same-cycle delay-table write and read to the same index returns the old value.

Reset asserted mid-operation: immediate return to reset values, with no done or aborted pulse.

Decomposition:
- Package glitch_pkg holds:
  - opcode constants I2C_CHK = 2'b00, DAC_UP = 2'b01, DELAY = 2'b10;
  - PRIV_BUS = 1, MAIN_BUS = 0, ACK = 0, NAK = 1;
  - instruction field offsets;
  - FSM state enum.
- Sub-module sync_ram (parametrised width and depth; one write port, one registered read port), instantiated once for instructions and once for delays.

Test Plan:
1. Load 3 instrs (0x210, 0x002, 0xBDA), len = 3, loop = 0, start, instr_ready tied high -> instr 0x210/pt 0, 0x002/pt 1, 0xBDA/pt 2 on alternating cycles; done pulses once; busy falls.
2. Same program, loop = 2 -> 9 handshakes, pt sequence 0,1,2 repeated 3 times, single done.
3. Backpressure: instr_ready low for 5 cycles in OFFER -> instr and instr_pt held constant, pc not advanced.
4. abort in the cycle of the 2nd handshake -> next cycle instr_valid = 0, aborted = 1, done never asserted, busy = 0.
5. len = 0, start -> done 1 cycle after start, instr_valid never high; ld_len = 100 then start -> 64 instructions streamed.
6. Delay table: write index 1 = 0x000F4240; read 1 -> 0x000F4240 after 1 cycle; read 20 -> 0; ld_delay_en while busy -> ld_err pulse, table unchanged.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: opcodes, bus/ack codes,
// instruction field offsets and the program store FSM state type.
package glitch_pkg;

    // Instruction opcodes (op field)
    localparam logic [1:0] I2C_CHK = 2'b00;
    localparam logic [1:0] DAC_UP  = 2'b01;
    localparam logic [1:0] DELAY   = 2'b10;

    // Bus select and expected acknowledge codes
    localparam logic PRIV_BUS = 1'b1;
    localparam logic MAIN_BUS = 1'b0;
    localparam logic ACK      = 1'b0;
    localparam logic NAK      = 1'b1;

    // Field offsets of the default 12-bit instruction {op[1:0], bus, data[7:0], ack}
    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 10;
    localparam int BUS_BIT  = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_LSB = 1;
    localparam int ACK_BIT  = 0;

    // Program store sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OFFER = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_ram.sv
// Simple single-write-port RAM with one registered read port (1-cycle latency).
// A read and write to the same address in one cycle returns the old contents.
module sync_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, holds its value when no read is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/program_store.sv
// Loadable program and delay store: the host loads instructions, delays,
// program length and loop count while idle; on start the program is streamed
// to the sequencer over valid/ready, repeated loop_cnt+1 times.
module program_store
    import glitch_pkg::*;
#(
    parameter  int INSTR_W    = 12,
    parameter  int PROG_DEPTH = 64,
    parameter  int DELAY_W    = 32,
    parameter  int NUM_DELAYS = 16,
    parameter  int LOOP_W     = 8,
    localparam int PA         = $clog2(PROG_DEPTH),
    localparam int DA         = $clog2(NUM_DELAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_instr_en,
    input  logic [PA-1:0]      ld_instr_addr,
    input  logic [INSTR_W-1:0] ld_instr_data,
    input  logic               ld_delay_en,
    input  logic [DA-1:0]      ld_delay_addr,
    input  logic [DELAY_W-1:0] ld_delay_data,
    input  logic               ld_len_en,
    input  logic [PA:0]        ld_len,
    input  logic               ld_loop_en,
    input  logic [LOOP_W-1:0]  ld_loop,
    output logic               ld_err,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PA-1:0]      instr_pt,
    output logic               done,
    output logic               aborted,
    input  logic               dly_rd_en,
    input  logic [7:0]         dly_rd_num,
    output logic               dly_rd_valid,
    output logic [DELAY_W-1:0] dly_rd_len
);

    localparam logic [PA:0] DEPTH_C  = (PA+1)'(PROG_DEPTH);
    localparam logic [8:0]  NUMDLY_C = 9'(NUM_DELAYS);

    state_t             r_state;
    state_t             w_state_next;
    logic [PA-1:0]      r_pc;
    logic [PA-1:0]      w_pc_next;
    logic [LOOP_W-1:0]  r_pass;
    logic [LOOP_W-1:0]  w_pass_next;
    logic [LOOP_W-1:0]  r_loop_cnt;
    logic [PA:0]        r_prog_len;
    logic               r_ld_err;
    logic               r_aborted;
    logic               r_dly_valid;
    logic               r_dly_oor;

    logic               w_idle;
    logic               w_load_any;
    logic               w_last;
    logic               w_dly_oor;
    logic [PA:0]        w_len_sat;
    logic [INSTR_W-1:0] w_instr_q;
    logic [DELAY_W-1:0] w_dly_q;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_load_any = ld_instr_en | ld_delay_en | ld_len_en | ld_loop_en;
    assign w_last     = ({1'b0, r_pc} == (r_prog_len - 1'b1));
    assign w_len_sat  = (ld_len > DEPTH_C) ? DEPTH_C : ld_len;
    assign w_dly_oor  = ({1'b0, dly_rd_num} >= NUMDLY_C);

    // Instruction memory: written only while idle, read when fetching
    sync_ram #(
        .WIDTH (INSTR_W),
        .DEPTH (PROG_DEPTH)
    ) u_instr_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (ld_instr_en & w_idle),
        .i_wr_addr (ld_instr_addr),
        .i_wr_data (ld_instr_data),
        .i_rd_en   (r_state == ST_FETCH),
        .i_rd_addr (r_pc),
        .o_rd_data (w_instr_q)
    );

    // Delay table: written only while idle, looked up at any time
    sync_ram #(
        .WIDTH (DELAY_W),
        .DEPTH (NUM_DELAYS)
    ) u_delay_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (ld_delay_en & w_idle),
        .i_wr_addr (ld_delay_addr),
        .i_wr_data (ld_delay_data),
        .i_rd_en   (dly_rd_en & ~w_dly_oor),
        .i_rd_addr (dly_rd_num[DA-1:0]),
        .o_rd_data (w_dly_q)
    );

    // Program length and loop count, only loadable while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_len <= '0;
            r_loop_cnt <= '0;
        end else if (w_idle) begin
            if (ld_len_en) begin
                r_prog_len <= w_len_sat;
            end
            if (ld_loop_en) begin
                r_loop_cnt <= ld_loop;
            end
        end
    end

    // Single-cycle status pulses and delay lookup bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_err    <= 1'b0;
            r_aborted   <= 1'b0;
            r_dly_valid <= 1'b0;
            r_dly_oor   <= 1'b0;
        end else begin
            r_ld_err    <= w_load_any & ~w_idle;
            r_aborted   <= abort & ~w_idle;
            r_dly_valid <= dly_rd_en;
            r_dly_oor   <= w_dly_oor;
        end
    end

    // Sequencer state, program counter and pass counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_pass  <= w_pass_next;
        end
    end

    // Next-state logic; abort outranks both start and a same-cycle handshake
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pass_next  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_pc_next    = '0;
                    w_pass_next  = '0;
                    w_state_next = (r_prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = abort ? ST_IDLE : ST_OFFER;
            end
            ST_OFFER: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (instr_ready) begin
                    if (w_last && (r_pass == r_loop_cnt)) begin
                        w_state_next = ST_DONE;
                    end else if (w_last) begin
                        w_pass_next  = r_pass + 1'b1;
                        w_pc_next    = '0;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy         = ~w_idle;
    assign instr_valid  = (r_state == ST_OFFER);
    assign done         = (r_state == ST_DONE);
    assign instr        = w_instr_q;
    assign instr_pt     = r_pc;
    assign ld_err       = r_ld_err;
    assign aborted      = r_aborted;
    assign dly_rd_valid = r_dly_valid;
    assign dly_rd_len   = (r_dly_valid && !r_dly_oor) ? w_dly_q : '0;

endmodule

// File: tb/tb_program_store.sv
// Self-checking bench for program_store: expected instruction streams are built
// as queues from the loaded program, length and loop count; delay lookups are
// checked against a shadow copy of the delay table.
module tb_program_store;

    localparam int INSTR_W    = 12;
    localparam int PROG_DEPTH = 64;
    localparam int DELAY_W    = 32;
    localparam int NUM_DELAYS = 16;
    localparam int LOOP_W     = 8;
    localparam int PA         = 6;
    localparam int DA         = 4;

    logic               clk;
    logic               rst_n;
    logic               ld_instr_en;
    logic [PA-1:0]      ld_instr_addr;
    logic [INSTR_W-1:0] ld_instr_data;
    logic               ld_delay_en;
    logic [DA-1:0]      ld_delay_addr;
    logic [DELAY_W-1:0] ld_delay_data;
    logic               ld_len_en;
    logic [PA:0]        ld_len;
    logic               ld_loop_en;
    logic [LOOP_W-1:0]  ld_loop;
    logic               ld_err;
    logic               start;
    logic               abort;
    logic               busy;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PA-1:0]      instr_pt;
    logic               done;
    logic               aborted;
    logic               dly_rd_en;
    logic [7:0]         dly_rd_num;
    logic               dly_rd_valid;
    logic [DELAY_W-1:0] dly_rd_len;

    program_store #(
        .INSTR_W    (INSTR_W),
        .PROG_DEPTH (PROG_DEPTH),
        .DELAY_W    (DELAY_W),
        .NUM_DELAYS (NUM_DELAYS),
        .LOOP_W     (LOOP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_instr_en   (ld_instr_en),
        .ld_instr_addr (ld_instr_addr),
        .ld_instr_data (ld_instr_data),
        .ld_delay_en   (ld_delay_en),
        .ld_delay_addr (ld_delay_addr),
        .ld_delay_data (ld_delay_data),
        .ld_len_en     (ld_len_en),
        .ld_len        (ld_len),
        .ld_loop_en    (ld_loop_en),
        .ld_loop       (ld_loop),
        .ld_err        (ld_err),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pt      (instr_pt),
        .done          (done),
        .aborted       (aborted),
        .dly_rd_en     (dly_rd_en),
        .dly_rd_num    (dly_rd_num),
        .dly_rd_valid  (dly_rd_valid),
        .dly_rd_len    (dly_rd_len)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;

    logic [INSTR_W-1:0] modelInstr [PROG_DEPTH];
    logic [DELAY_W-1:0] modelDelay [NUM_DELAYS];
    int                 modelLen  = 0;
    int                 modelLoop = 0;
    int                 expPt[$];
    logic [INSTR_W-1:0] expIns[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic loadInstr(input int a, input logic [INSTR_W-1:0] d);
        ld_instr_en   = 1'b1;
        ld_instr_addr = a[PA-1:0];
        ld_instr_data = d;
        tick();
        ld_instr_en   = 1'b0;
        modelInstr[a] = d;
    endtask

    task automatic loadDelay(input int a, input logic [DELAY_W-1:0] d);
        ld_delay_en   = 1'b1;
        ld_delay_addr = a[DA-1:0];
        ld_delay_data = d;
        tick();
        ld_delay_en   = 1'b0;
        modelDelay[a] = d;
    endtask

    task automatic loadLen(input int n);
        ld_len_en = 1'b1;
        ld_len    = n[PA:0];
        tick();
        ld_len_en = 1'b0;
        modelLen  = (n > PROG_DEPTH) ? PROG_DEPTH : n;
    endtask

    task automatic loadLoop(input int n);
        ld_loop_en = 1'b1;
        ld_loop    = n[LOOP_W-1:0];
        tick();
        ld_loop_en = 1'b0;
        modelLoop  = n;
    endtask

    task automatic readDelay(input int idx, input string tag);
        logic [DELAY_W-1:0] exp;
        exp        = (idx < NUM_DELAYS) ? modelDelay[idx] : '0;
        dly_rd_en  = 1'b1;
        dly_rd_num = idx[7:0];
        tick();
        dly_rd_en  = 1'b0;
        checkOutput({tag, "_valid"}, dly_rd_valid, 1'b1);
        checkOutput(tag, dly_rd_len, exp);
    endtask

    // Run one program from start to done/abort, checking every offered instruction
    task automatic applyStimulus(input int readyPct, input int holdCycles, input int abortAt, input string tag);
        int                 hs, offers, doneCount, abortCount, doneCycle, validCount, cyc, totalExp;
        bit                 fin, prevHeld, rdy;
        logic [INSTR_W-1:0] prevIns;
        logic [PA-1:0]      prevPt;
        hs = 0; offers = 0; doneCount = 0; abortCount = 0; doneCycle = -1; validCount = 0;
        fin = 1'b0; prevHeld = 1'b0; prevIns = '0; prevPt = '0;
        expPt.delete();
        expIns.delete();
        for (int p = 0; p <= modelLoop; p++) begin
            for (int i = 0; i < modelLen; i++) begin
                expPt.push_back(i);
                expIns.push_back(modelInstr[i]);
            end
        end
        totalExp = expPt.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc <= 4000) begin
            if (done) begin
                doneCount++;
                doneCycle = cyc;
                checkOutput({tag, "_done_queue_left"}, expPt.size(), 0);
            end
            if (aborted) abortCount++;
            if (!busy) begin
                fin = 1'b1;
                checkOutput({tag, "_idle_valid"}, instr_valid, 1'b0);
            end else if (instr_valid) begin
                validCount++;
                if (prevHeld) begin
                    checkOutput({tag, "_hold_instr"}, instr, prevIns);
                    checkOutput({tag, "_hold_pt"}, instr_pt, prevPt);
                end
                checkOutput({tag, "_offer_expected"}, expPt.size() > 0, 1'b1);
                if (expPt.size() > 0) begin
                    checkOutput({tag, "_pt"}, instr_pt, expPt[0]);
                    checkOutput({tag, "_instr"}, instr, expIns[0]);
                end
                rdy = (offers >= holdCycles) && ($urandom_range(0, 99) < readyPct);
                offers++;
                if (rdy) begin
                    hs++;
                    if (expPt.size() > 0) begin
                        void'(expPt.pop_front());
                        void'(expIns.pop_front());
                    end
                    prevHeld = 1'b0;
                    if (hs == abortAt) abort = 1'b1;
                end else begin
                    prevHeld = 1'b1;
                    prevIns  = instr;
                    prevPt   = instr_pt;
                end
                instr_ready = rdy;
            end else begin
                prevHeld    = 1'b0;
                instr_ready = 1'($urandom_range(0, 1));
            end
            if (!fin) begin
                tick();
                abort = 1'b0;
                cyc++;
            end
        end
        instr_ready = 1'b0;
        abort       = 1'b0;
        if (!fin) checkOutput({tag, "_timeout"}, fin, 1'b1);
        tick();
        checkOutput({tag, "_done_pulse_end"}, done, 1'b0);
        checkOutput({tag, "_aborted_pulse_end"}, aborted, 1'b0);
        if (abortAt > 0) begin
            checkOutput({tag, "_aborted_count"}, abortCount, 1);
            checkOutput({tag, "_done_count"}, doneCount, 0);
            checkOutput({tag, "_handshakes"}, hs, abortAt);
        end else begin
            checkOutput({tag, "_done_count"}, doneCount, 1);
            checkOutput({tag, "_aborted_count"}, abortCount, 0);
            checkOutput({tag, "_handshakes"}, hs, totalExp);
            if (modelLen == 0) begin
                checkOutput({tag, "_done_cycle"}, doneCycle, 1);
                checkOutput({tag, "_valid_count"}, validCount, 0);
            end
        end
    endtask

    // Directed scenarios followed by randomized programs and lookups
    initial begin
        rst_n = 1'b0;
        ld_instr_en = 1'b0; ld_instr_addr = '0; ld_instr_data = '0;
        ld_delay_en = 1'b0; ld_delay_addr = '0; ld_delay_data = '0;
        ld_len_en = 1'b0; ld_len = '0; ld_loop_en = 1'b0; ld_loop = '0;
        start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
        dly_rd_en = 1'b0; dly_rd_num = '0;
        repeat (3) tick();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_aborted", aborted, 1'b0);
        checkOutput("rst_ld_err", ld_err, 1'b0);
        checkOutput("rst_instr", instr, '0);
        checkOutput("rst_pt", instr_pt, '0);
        checkOutput("rst_dly_valid", dly_rd_valid, 1'b0);
        checkOutput("rst_dly_len", dly_rd_len, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NUM_DELAYS; i++) loadDelay(i, $urandom);
        checkOutput("idle_load_no_err", ld_err, 1'b0);

        loadInstr(0, 12'h210);
        loadInstr(1, 12'h002);
        loadInstr(2, 12'hBDA);
        loadLen(3);
        loadLoop(0);
        applyStimulus(100, 0, -1, "t1_basic");

        loadLoop(2);
        applyStimulus(100, 0, -1, "t2_loop");

        applyStimulus(100, 5, -1, "t3_hold");

        loadLoop(0);
        applyStimulus(100, 0, 2, "t4_abort");

        loadLen(0);
        applyStimulus(100, 0, -1, "t5_len0");
        for (int i = 0; i < PROG_DEPTH; i++) loadInstr(i, INSTR_W'($urandom));
        loadLen(100);
        applyStimulus(100, 0, -1, "t5_sat");

        loadDelay(1, 32'h000F4240);
        readDelay(1, "t6_rd1");
        tick();
        checkOutput("t6_valid_drop", dly_rd_valid, 1'b0);
        readDelay(20, "t6_rd20");

        loadLen(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_delay_en = 1'b1; ld_delay_addr = 4'd1; ld_delay_data = 32'hDEADBEEF;
        ld_instr_en = 1'b1; ld_instr_addr = '0; ld_instr_data = ~modelInstr[0];
        tick();
        ld_delay_en = 1'b0;
        ld_instr_en = 1'b0;
        checkOutput("t6_ld_err", ld_err, 1'b1);
        tick();
        checkOutput("t6_ld_err_pulse", ld_err, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t6_abort_aborted", aborted, 1'b1);
        checkOutput("t6_abort_busy", busy, 1'b0);
        readDelay(1, "t6_table_unchanged");
        applyStimulus(100, 0, -1, "t6_prog_unchanged");

        ld_delay_en = 1'b1; ld_delay_addr = 4'd5; ld_delay_data = 32'h12345678;
        dly_rd_en = 1'b1; dly_rd_num = 8'd5;
        tick();
        ld_delay_en = 1'b0;
        dly_rd_en = 1'b0;
        checkOutput("rw_same_old", dly_rd_len, modelDelay[5]);
        modelDelay[5] = 32'h12345678;
        readDelay(5, "rw_same_new");

        for (int k = 0; k < 10; k++) readDelay($urandom_range(0, 31), "rand_dly");

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", busy, 1'b0);
        checkOutput("start_abort_aborted", aborted, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) loadInstr(i, INSTR_W'($urandom));
            loadLen(n);
            loadLoop($urandom_range(0, 3));
            applyStimulus($urandom_range(30, 100), 0, -1, "rand_prog");
        end

        loadLen(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_valid", instr_valid, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        tick();
        checkOutput("midrst_aborted", aborted, 1'b0);
        rst_n = 1'b1;
        tick();
        modelLen  = 0;
        modelLoop = 0;
        applyStimulus(100, 0, -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
